// File: rtl/qoi_stream_framer_pkg.sv
// Shared QOI constants, framer state type and header packing helper.
package qoi_pkg;

    localparam logic [31:0] QOI_MAGIC      = 32'h716F6966;
    localparam logic [63:0] QOI_END_MARKER = 64'h0000_0000_0000_0001;
    localparam int          QOI_HDR_LEN    = 14;
    localparam int          QOI_END_LEN    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        BODY    = 2'd2,
        TRAILER = 2'd3
    } framer_state_t;

    // Packs the 14 header bytes, first transmitted byte in the MSBs.
    function automatic logic [111:0] qoi_header(
        input logic [31:0] width,
        input logic [31:0] height,
        input logic [7:0]  channels,
        input logic [7:0]  colorspace
    );
        return {QOI_MAGIC, width, height, channels, colorspace};
    endfunction

endpackage

// File: rtl/qoi_stream_framer_if.sv
// Byte stream with valid/ready handshake and an end-of-stream flag.
interface qoi_stream_framer_if;

    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/qoi_stream_framer_fifo.sv
// Small synchronous FIFO with combinational head read and occupancy count.
module qoi_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    // The head must be visible the cycle after a push into an empty FIFO,
    // so the read is taken straight from the storage array.
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally; occupancy tracks push/pop balance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/qoi_stream_framer.sv
// Wraps the encoder chunk stream into a .qoi file: header, body, end marker.
module qoi_stream_framer
    import qoi_pkg::*;
#(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int CHANNELS   = 4,
    parameter int COLORSPACE = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    qoi_stream_framer_if.slave   enc,
    qoi_stream_framer_if.master  host,
    output logic                 busy,
    output logic                 frame_done,
    output logic [31:0]          body_count
);

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam logic [111:0] HDR_VEC = qoi_header(32'(IMG_WIDTH), 32'(IMG_HEIGHT),
                                                  8'(CHANNELS), 8'(COLORSPACE));

    framer_state_t state;
    framer_state_t state_next;
    logic [3:0]    hdr_idx;
    logic [3:0]    hdr_idx_next;
    logic [2:0]    tr_idx;
    logic [2:0]    tr_idx_next;
    logic          frame_done_next;
    logic          count_clear;
    logic          count_inc;

    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_byte;
    logic          out_last;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [8:0]    fifo_head;
    logic [FIFO_AW:0] fifo_count_unused;

    logic [7:0]    hdr_bytes [16];
    logic [7:0]    end_bytes [8];

    // Header and end-marker byte tables, indexed by the byte counters.
    for (genvar gi = 0; gi < 16; gi++) begin : g_hdr
        if (gi < QOI_HDR_LEN) begin : g_used
            assign hdr_bytes[gi] = HDR_VEC[8*(QOI_HDR_LEN-1-gi) +: 8];
        end else begin : g_pad
            assign hdr_bytes[gi] = 8'h00;
        end
    end
    for (genvar gi = 0; gi < QOI_END_LEN; gi++) begin : g_end
        assign end_bytes[gi] = QOI_END_MARKER[8*(QOI_END_LEN-1-gi) +: 8];
    end

    // Occupancy is exported for debug; the framer only needs the flags.
    qoi_byte_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wdata   ({enc.last, enc.data}),
        .pop     (fifo_pop),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count_unused)
    );

    assign fifo_push  = enc.valid && in_ready;
    assign enc.ready  = in_ready;
    assign host.valid = out_valid;
    assign host.data  = out_byte;
    assign host.last  = out_last;
    assign busy       = (state != IDLE);

    // State, byte indices, saturating body counter and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hdr_idx    <= '0;
            tr_idx     <= '0;
            frame_done <= 1'b0;
            body_count <= '0;
        end else begin
            state      <= state_next;
            hdr_idx    <= hdr_idx_next;
            tr_idx     <= tr_idx_next;
            frame_done <= frame_done_next;
            if (count_clear) begin
                body_count <= '0;
            end else if (count_inc && (body_count != 32'hFFFF_FFFF)) begin
                body_count <= body_count + 32'd1;
            end
        end
    end

    // Next-state and output selection; start is ignored while frame_done
    // is still high so a frame cannot restart in its own completion cycle.
    always_comb begin
        state_next      = state;
        hdr_idx_next    = hdr_idx;
        tr_idx_next     = tr_idx;
        frame_done_next = 1'b0;
        count_clear     = 1'b0;
        count_inc       = 1'b0;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        out_byte        = 8'h00;
        out_last        = 1'b0;
        fifo_pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !frame_done) begin
                    state_next   = HEADER;
                    hdr_idx_next = '0;
                    count_clear  = 1'b1;
                end
            end
            HEADER: begin
                in_ready  = !fifo_full;
                out_valid = 1'b1;
                out_byte  = hdr_bytes[hdr_idx];
                if (host.ready) begin
                    if (hdr_idx == 4'(QOI_HDR_LEN-1)) begin
                        state_next = BODY;
                    end else begin
                        hdr_idx_next = hdr_idx + 4'd1;
                    end
                end
            end
            BODY: begin
                in_ready  = !fifo_full;
                out_valid = !fifo_empty;
                out_byte  = fifo_head[7:0];
                if (!fifo_empty && host.ready) begin
                    fifo_pop  = 1'b1;
                    count_inc = 1'b1;
                    if (fifo_head[8]) begin
                        state_next  = TRAILER;
                        tr_idx_next = '0;
                    end
                end
            end
            TRAILER: begin
                out_valid = 1'b1;
                out_byte  = end_bytes[tr_idx];
                out_last  = (tr_idx == 3'(QOI_END_LEN-1));
                if (host.ready) begin
                    if (out_last) begin
                        state_next      = IDLE;
                        frame_done_next = 1'b1;
                    end else begin
                        tr_idx_next = tr_idx + 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_qoi_stream_framer.sv
// Self-checking bench for qoi_stream_framer (W=4, H=2, RGBA, sRGB).
module tb_qoi_stream_framer;

    localparam int W = 4, H = 2, CH = 4, CS = 0, DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [31:0] body_count;

    qoi_stream_framer_if enc_if ();
    qoi_stream_framer_if host_if ();

    qoi_stream_framer #(
        .IMG_WIDTH (W), .IMG_HEIGHT (H), .CHANNELS (CH),
        .COLORSPACE (CS), .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk), .reset_n (reset_n), .start (start),
        .enc (enc_if), .host (host_if),
        .busy (busy), .frame_done (frame_done), .body_count (body_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      field;
        bit         is_body;
        logic [7:0] in_byte;
        bit         in_last;
        logic [7:0] exp_byte;
    } vec_t;

    logic [7:0] ref_bytes [25] = '{8'h71, 8'h6F, 8'h69, 8'h66, 8'h00, 8'h00, 8'h00, 8'h04,
                                   8'h00, 8'h00, 8'h00, 8'h02, 8'h04, 8'h00, 8'hFE, 8'h10,
                                   8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                   8'h01};
    vec_t       tbl [25];

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         ready_pct = 100;
    bit         abort = 1'b0;
    int         start_cyc = 0;
    logic [7:0] cap[$];
    int         stamp[$];
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         stall_err = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Cycle stamp for latency/gap checks.
    always @(posedge clk) cyc++;

    // Downstream ready: fraction ready_pct of cycles high.
    initial begin
        host_if.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            host_if.ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Output monitor sampled mid-cycle; a transfer occurs at the next edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(host_if.valid && host_if.data == prev_byte)) stall_err++;
            if (host_if.valid && host_if.ready) begin
                cap.push_back(host_if.data);
                stamp.push_back(cyc);
            end
            if (frame_done) done_cnt++;
            prev_stall = host_if.valid && !host_if.ready;
            prev_byte  = host_if.data;
        end
    end

    // Reference: file = magic, BE width, BE height, channels, colorspace, body, 7x00, 01.
    task automatic build_expected(input logic [7:0] body[$]);
        exp_q.delete();
        exp_q.push_back(8'h71); exp_q.push_back(8'h6F);
        exp_q.push_back(8'h69); exp_q.push_back(8'h66);
        for (int k = 3; k >= 0; k--) exp_q.push_back(8'((W >> (8*k)) & 255));
        for (int k = 3; k >= 0; k--) exp_q.push_back(8'((H >> (8*k)) & 255));
        exp_q.push_back(8'(CH));
        exp_q.push_back(8'(CS));
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap.size()) check($sformatf("%s[%0d]", name, i), cap[i], exp_q[i]);
        end
    endtask

    task automatic check_no_gap(input string name);
        for (int i = 1; i < stamp.size(); i++) begin
            check($sformatf("%s_gap[%0d]", name, i), stamp[i] - stamp[i-1], 1);
        end
    endtask

    // Presents bytes one at a time, holding each until accepted; call at posedge+1.
    task automatic drive_enc(input logic [7:0] body[$]);
        for (int i = 0; i < body.size(); i++) begin
            bit acc = 1'b0;
            int budget = 2000;
            enc_if.valid = 1'b1;
            enc_if.data  = body[i];
            enc_if.last  = (i == body.size() - 1);
            while (!acc && !abort && budget > 0) begin
                @(negedge clk);
                acc = enc_if.ready;
                @(posedge clk);
                #1;
                budget--;
            end
            if (abort) break;
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL enc_accept: byte %0d accepted=0 required=1", i);
                break;
            end
        end
        enc_if.valid = 1'b0;
        enc_if.last  = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int budget = 3000;
        while (done_cnt == d0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL frame_done_timeout: done_count=%0d required>%0d", done_cnt, d0);
        end
    endtask

    task automatic wait_cap(input int n);
        int budget = 2000;
        while (cap.size() < n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("wait_cap", (cap.size() >= n), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] body[$], input bit do_start);
        int d0 = done_cnt;
        cap.delete();
        stamp.delete();
        if (do_start) pulse_start();
        fork
            drive_enc(body);
            wait_done(d0);
        join
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   enc_if.ready, 0);
        check({tag, "_out_valid"},  host_if.valid, 0);
        check({tag, "_out_byte"},   host_if.data, 0);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_body_count"}, body_count, 0);
    endtask

    initial begin
        logic [7:0] body1[$];
        logic [7:0] rbody[$];
        int d0;

        enc_if.valid = 1'b0;
        enc_if.data  = 8'h00;
        enc_if.last  = 1'b0;

        // Directed vector table: inputs for body rows, expected file byte for every row.
        for (int i = 0; i < 25; i++) begin
            tbl[i].exp_byte = ref_bytes[i];
            tbl[i].is_body  = (i >= 14 && i < 17);
            tbl[i].in_byte  = tbl[i].is_body ? ref_bytes[i] : 8'h00;
            tbl[i].in_last  = (i == 16);
            tbl[i].field    = (i < 4) ? "magic" : (i < 8) ? "width" : (i < 12) ? "height" :
                              (i == 12) ? "channels" : (i == 13) ? "colorspace" :
                              (i < 17) ? "body" : "end";
        end
        for (int i = 0; i < 25; i++) if (tbl[i].is_body) body1.push_back(tbl[i].in_byte);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: bytes offered before start stall; then the reference frame, no gaps.
        ready_pct = 100;
        d0 = done_cnt;
        cap.delete();
        stamp.delete();
        fork
            drive_enc(body1);
            begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("idle_in_ready[%0d]", k), enc_if.ready, 0);
                    @(posedge clk);
                    #1;
                end
                check("idle_busy", busy, 0);
                pulse_start();
                wait_done(d0);
            end
        join
        for (int i = 0; i < 25; i++) begin
            if (i < cap.size()) check($sformatf("t1_%s[%0d]", tbl[i].field, i), cap[i], tbl[i].exp_byte);
        end
        check("t1_len", cap.size(), 25);
        if (stamp.size() > 0) check("t1_first_latency", stamp[0], start_cyc);
        check_no_gap("t1");
        check("t1_body_count", body_count, 3);
        repeat (3) @(posedge clk);
        #1;
        check("t1_done_pulses", done_cnt - d0, 1);

        // Test 2: ~50% downstream stalls, identical stream, stable held byte.
        ready_pct = 50;
        run_frame(body1, 1'b1);
        for (int i = 0; i < 25; i++) begin
            if (i < cap.size()) check($sformatf("t2_%s[%0d]", tbl[i].field, i), cap[i], tbl[i].exp_byte);
        end
        check("t2_len", cap.size(), 25);
        check("t2_stall_hold", stall_err, 0);

        // Test 3: downstream blocked in BODY; FIFO fills at 8, the 9th byte is held.
        ready_pct = 100;
        rbody.delete();
        for (int i = 0; i < 9; i++) rbody.push_back(8'(8'h30 + i));
        build_expected(rbody);
        d0 = done_cnt;
        cap.delete();
        stamp.delete();
        pulse_start();
        wait_cap(14);
        ready_pct = 0;
        repeat (2) @(posedge clk);
        #1;
        fork
            drive_enc(rbody);
            begin
                repeat (14) @(posedge clk);
                #1;
                check("t3_in_ready_full", enc_if.ready, 0);
                check("t3_ninth_held", enc_if.data, rbody[8]);
                check("t3_no_out", cap.size(), 14);
                check("t3_head_valid", host_if.valid, 1);
                check("t3_head_byte", host_if.data, rbody[0]);
                ready_pct = 100;
                wait_done(d0);
            end
        join
        compare_stream("t3");
        check("t3_body_count", body_count, 9);

        // Test 4: random frames against the reference model (first has a 1-byte body).
        for (int f = 0; f < 6; f++) begin
            int len = (f == 0) ? 1 : $urandom_range(1, 24);
            ready_pct = (f == 1) ? 100 : $urandom_range(25, 100);
            rbody.delete();
            for (int i = 0; i < len; i++) rbody.push_back(8'($urandom_range(0, 255)));
            build_expected(rbody);
            run_frame(rbody, 1'b1);
            compare_stream($sformatf("rand%0d", f));
            check($sformatf("rand%0d_body_count", f), body_count, len);
            if (f == 1) check_no_gap("rand1");
        end
        check("rand_stall_hold", stall_err, 0);

        // Test 5: asynchronous reset mid-BODY, then a fresh frame.
        ready_pct = 50;
        rbody.delete();
        for (int i = 0; i < 20; i++) rbody.push_back(8'($urandom_range(1, 255)));
        cap.delete();
        stamp.delete();
        pulse_start();
        fork
            drive_enc(rbody);
            begin
                wait_cap(16);
                check("t5_busy_before", busy, 1);
                check("t5_count_before", (body_count >= 2), 1);
                #2;
                reset_n = 1'b0;
                #1;
                check_reset_outputs("t5_async");
                abort = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        abort = 1'b0;
        ready_pct = 100;
        build_expected(body1);
        run_frame(body1, 1'b1);
        compare_stream("t5_fresh");
        check("t5_body_count", body_count, 3);
        if (stamp.size() > 0) check("t5_first_latency", stamp[0], start_cyc);

        // Test 6: start in TRAILER and with frame_done ignored; one cycle later accepted.
        ready_pct = 100;
        d0 = done_cnt;
        cap.delete();
        stamp.delete();
        pulse_start();
        fork
            drive_enc(body1);
            begin
                int budget = 200;
                wait_cap(18);
                pulse_start();
                while (!frame_done && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
                check("t6_done_seen", frame_done, 1);
                start = 1'b1;
                @(posedge clk);
                #1;
                check("t6_start_with_done_ignored", busy, 0);
                @(posedge clk);
                #1;
                start = 1'b0;
                check("t6_start_after_done", busy, 1);
            end
        join
        compare_stream("t6_first");
        check("t6_done_pulses", done_cnt - d0, 1);
        run_frame(body1, 1'b0);
        compare_stream("t6_second");
        check("t6_second_body_count", body_count, 3);
        check("final_stall_hold", stall_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
